fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined LEGv8 CPU: owns the program counter, issues one-outstanding-request fetches to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register consumed by decode. It sits directly upstream of decode and the hazard-detection/forwarding logic. It honours load-use stalls from the hazard-detection unit and branch redirects/flushes from the execute/memory stage.

---
 rtl/legv8_pkg.sv | 8 +
 rtl/fetch_skid_buf.sv | 37 +++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared widths, fetch-state encoding and constants for the LEGv8 pipeline
package legv8_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_INC = 4;
  localparam logic [31:0] NOP = 32'hD503_201F;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DISCARD, ST_BUF} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: single-entry {pc, instr} holding register for a fetch that returns during a stall
// ports: clk, rst_n (async active-low), i_load/i_unload/i_clear controls, i_pc/i_instr data in, o_valid/o_pc/o_instr held entry
module fetch_skid_buf #(
  parameter int ADDR_W = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic               i_clear,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr
);
  logic               r_valid;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear || i_unload) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end
  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction fetch with PC, req/ack imem port, stall/redirect handling and IF/ID register
// ports: clk, Reset (async active-low); imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
//        stall_i, redirect_i, redirect_pc_i pipeline control; ifid_valid_o/ifid_pc_o/ifid_instr_o IF/ID register
module fetch_stage
  import legv8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               Reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               ifid_valid_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o
);
  fetch_state_e       r_state, w_next;
  logic [ADDR_W-1:0]  r_pc, r_stale;
  logic               r_ifid_valid;
  logic [ADDR_W-1:0]  r_ifid_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic               w_fetch, w_unload, w_buf_valid;
  logic [ADDR_W-1:0]  w_buf_pc;
  logic [INSTR_W-1:0] w_buf_instr;
  assign w_fetch  = (r_state == ST_REQ) && imem_ack;
  assign w_unload = (r_state == ST_BUF) && !stall_i && !redirect_i;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end
  // DISCARD only waits out the abandoned fetch, so a redirect there does not change its exit
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = ST_REQ;
      ST_REQ:     w_next = redirect_i ? (imem_ack ? ST_REQ : ST_DISCARD) : (imem_ack && stall_i) ? ST_BUF : ST_REQ;
      ST_DISCARD: w_next = imem_ack ? ST_REQ : ST_DISCARD;
      ST_BUF:     w_next = (redirect_i || !stall_i) ? ST_REQ : ST_BUF;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_comb begin
    imem_req  = (r_state == ST_REQ) || (r_state == ST_DISCARD);
    imem_addr = (r_state == ST_DISCARD) ? r_stale : r_pc;
  end
  // r_stale tracks the in-flight address so DISCARD keeps presenting it after pc jumps
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_pc    <= RESET_PC;
      r_stale <= RESET_PC;
    end else begin
      if (r_state == ST_REQ) r_stale <= r_pc;
      if (redirect_i)   r_pc <= redirect_pc_i & ~ADDR_W'(3);
      else if (w_fetch) r_pc <= r_pc + ADDR_W'(PC_INC);
    end
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else if (redirect_i) begin
      r_ifid_valid <= 1'b0;
    end else if (!stall_i) begin
      r_ifid_valid <= w_fetch || (w_unload && w_buf_valid);
      if (w_fetch) begin
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= imem_rdata;
      end else if (w_unload) begin
        r_ifid_pc    <= w_buf_pc;
        r_ifid_instr <= w_buf_instr;
      end
    end
  end
  fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .rst_n   (Reset),
    .i_load  (w_fetch && stall_i && !redirect_i),
    .i_unload(w_unload),
    .i_clear (redirect_i),
    .i_pc    (r_pc),
    .i_instr (imem_rdata),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_instr (w_buf_instr)
  );
  assign ifid_valid_o = r_ifid_valid;
  assign ifid_pc_o    = r_ifid_pc;
  assign ifid_instr_o = r_ifid_instr;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a wait-state memory responder
module tb_fetch_stage;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
  logic        clk = 0, Reset = 1, ack = 0, stall = 0, redirect = 0;
  logic [63:0] rpc = '0;
  logic        req, v, req_w, v_w;
  logic [63:0] addr, ipc, addr_w, ipc_w;
  logic [31:0] rdata, ins, rdata_w, ins_w;
  int          mem_wait = 0, cnt = 0, errors = 0, checks = 0;
  assign rdata   = addr[31:0];
  assign rdata_w = addr_w[31:0];
  always #5 clk = ~clk;
  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk(clk), .Reset(Reset), .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(rpc),
    .ifid_valid_o(v), .ifid_pc_o(ipc), .ifid_instr_o(ins));
  fetch_stage #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .Reset(Reset), .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack), .imem_rdata(rdata_w),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(rpc),
    .ifid_valid_o(v_w), .ifid_pc_o(ipc_w), .ifid_instr_o(ins_w));
  initial forever begin
    @(negedge clk);
    if (!Reset || !req) begin ack = 0; cnt = 0; end
    else if (cnt == mem_wait) begin ack = 1; cnt = 0; end
    else begin ack = 0; cnt++; end
  end
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic do_reset(input int w);
    Reset = 0; stall = 0; redirect = 0; rpc = '0; mem_wait = w;
    @(posedge clk); #1;
    Reset = 1;
  endtask
  task automatic test_reset;
    Reset = 1; #2; Reset = 0; #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", req); end
    checks++; if (addr !== 64'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", addr); end
    checks++; if ({v, ipc, ins} !== 97'h0) begin errors++; $display("FAIL rst_ifid got v=%0h pc=%0h i=%0h exp 0", v, ipc, ins); end
    checks++; if (addr_w !== WRAP_PC) begin errors++; $display("FAIL rst_addr_w got=%0h exp=%0h", addr_w, WRAP_PC); end
  endtask
  task automatic test_zero_wait;
    do_reset(0);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL zw_first_idle got=%0h exp=0", req); end
    tick;
    checks++; if (req !== 1'b1 || addr !== 64'h0 || v !== 1'b0) begin errors++; $display("FAIL zw_first_req got req=%0h a=%0h v=%0h exp 1/0/0", req, addr, v); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (v !== 1'b1 || ipc !== 64'(4*i) || ins !== 32'(4*i)) begin errors++; $display("FAIL zw_ifid%0d got v=%0h pc=%0h i=%0h exp 1/%0h", i, v, ipc, ins, 4*i); end
    end
  endtask
  task automatic test_wait2;
    do_reset(2);
    tick;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 3; j++) begin
      checks++; if (req !== 1'b1 || addr !== 64'(4*k)) begin errors++; $display("FAIL w2_req k%0d j%0d got req=%0h a=%0h exp 1/%0h", k, j, req, addr, 4*k); end
      tick;
      checks++; if (v !== (j == 2)) begin errors++; $display("FAIL w2_valid k%0d j%0d got=%0h exp=%0h", k, j, v, j == 2); end
      if (j == 2) begin
        checks++; if (ipc !== 64'(4*k)) begin errors++; $display("FAIL w2_pc k%0d got=%0h exp=%0h", k, ipc, 4*k); end
      end
    end
  endtask
  task automatic test_stall;
    do_reset(0);
    repeat (6) tick;
    checks++; if (v !== 1'b1 || ipc !== 64'h10) begin errors++; $display("FAIL st_pre got v=%0h pc=%0h exp 1/10", v, ipc); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (v !== 1'b1 || ipc !== 64'h10 || req !== 1'b0) begin errors++; $display("FAIL st_hold%0d got v=%0h pc=%0h req=%0h exp 1/10/0", i, v, ipc, req); end
    end
    stall = 0;
    tick;
    checks++; if (v !== 1'b1 || ipc !== 64'h14 || ins !== 32'h14) begin errors++; $display("FAIL st_release got v=%0h pc=%0h i=%0h exp 1/14/14", v, ipc, ins); end
    checks++; if (req !== 1'b1 || addr !== 64'h18) begin errors++; $display("FAIL st_resume got req=%0h a=%0h exp 1/18", req, addr); end
    tick;
    checks++; if (v !== 1'b1 || ipc !== 64'h18) begin errors++; $display("FAIL st_next got v=%0h pc=%0h exp 1/18", v, ipc); end
  endtask
  task automatic test_redirect;
    do_reset(2);
    for (int n = 0; n < 40 && addr !== 64'h20; n++) tick;
    checks++; if (addr !== 64'h20 || v !== 1'b1 || ipc !== 64'h1C) begin errors++; $display("FAIL rd_reach got a=%0h v=%0h pc=%0h exp 20/1/1c", addr, v, ipc); end
    tick;
    redirect = 1; rpc = 64'h103;
    tick;
    redirect = 0;
    checks++; if (v !== 1'b0 || req !== 1'b1 || addr !== 64'h20) begin errors++; $display("FAIL rd_discard got v=%0h req=%0h a=%0h exp 0/1/20", v, req, addr); end
    tick;
    checks++; if (v !== 1'b0 || req !== 1'b1 || addr !== 64'h100) begin errors++; $display("FAIL rd_drop got v=%0h req=%0h a=%0h exp 0/1/100", v, req, addr); end
    for (int j = 0; j < 3; j++) begin
      tick;
      checks++; if (v !== (j == 2)) begin errors++; $display("FAIL rd_wait%0d got v=%0h exp=%0h", j, v, j == 2); end
    end
    checks++; if (ipc !== 64'h100 || ins !== 32'h100) begin errors++; $display("FAIL rd_target got pc=%0h i=%0h exp 100/100", ipc, ins); end
  endtask
  task automatic test_redirect_stall;
    do_reset(0);
    repeat (3) tick;
    checks++; if (v !== 1'b1 || ipc !== 64'h4) begin errors++; $display("FAIL rs_pre got v=%0h pc=%0h exp 1/4", v, ipc); end
    stall = 1; redirect = 1; rpc = 64'h200;
    tick;
    stall = 0; redirect = 0;
    checks++; if (v !== 1'b0 || req !== 1'b1 || addr !== 64'h200) begin errors++; $display("FAIL rs_flush got v=%0h req=%0h a=%0h exp 0/1/200", v, req, addr); end
    tick;
    checks++; if (v !== 1'b1 || ipc !== 64'h200 || ins !== 32'h200) begin errors++; $display("FAIL rs_target got v=%0h pc=%0h i=%0h exp 1/200/200", v, ipc, ins); end
  endtask
  task automatic test_wrap;
    do_reset(0);
    tick;
    checks++; if (req_w !== 1'b1 || addr_w !== WRAP_PC) begin errors++; $display("FAIL wr_addr got req=%0h a=%0h exp 1/%0h", req_w, addr_w, WRAP_PC); end
    tick;
    checks++; if (v_w !== 1'b1 || ipc_w !== WRAP_PC || ins_w !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wr_f8 got v=%0h pc=%0h i=%0h", v_w, ipc_w, ins_w); end
    tick;
    checks++; if (v_w !== 1'b1 || ipc_w !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wr_fc got v=%0h pc=%0h exp 1/..fc", v_w, ipc_w); end
    tick;
    checks++; if (v_w !== 1'b1 || ipc_w !== 64'h0 || ins_w !== 32'h0) begin errors++; $display("FAIL wr_zero got v=%0h pc=%0h i=%0h exp 1/0/0", v_w, ipc_w, ins_w); end
    tick;
    mem_wait = 2;
    tick;
    checks++; if (req_w !== 1'b1 || addr_w !== 64'h8 || v_w !== 1'b0) begin errors++; $display("FAIL wr_midwait got req=%0h a=%0h v=%0h exp 1/8/0", req_w, addr_w, v_w); end
    #2; Reset = 0; #1;
    checks++; if (req_w !== 1'b0 || addr_w !== WRAP_PC || {v_w, ipc_w, ins_w} !== 97'h0) begin errors++; $display("FAIL wr_async_rst got req=%0h a=%0h v=%0h pc=%0h i=%0h", req_w, addr_w, v_w, ipc_w, ins_w); end
    checks++; if (req !== 1'b0 || addr !== 64'h0 || {v, ipc, ins} !== 97'h0) begin errors++; $display("FAIL wr_async_rst0 got req=%0h a=%0h v=%0h pc=%0h", req, addr, v, ipc); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset;
    test_zero_wait;
    test_wait2;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
